// File: rtl/uv_spi_pkg.sv
// rtl/uv_spi_pkg.sv - shared SPI frame-size encodings and helpers
package uv_spi_pkg;

  localparam logic [1:0] FSZ_8  = 2'd0;
  localparam logic [1:0] FSZ_16 = 2'd1;
  localparam logic [1:0] FSZ_32 = 2'd2;

  localparam int SPI_FRM_DW = 32;

  // Encoding 3 is deliberately folded onto 32 bits.
  function automatic logic [5:0] fsz_bits(input logic [1:0] fsz);
    case (fsz)
      FSZ_8:   return 6'd8;
      FSZ_16:  return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/uv_queue.sv
// rtl/uv_queue.sv - pointer-based word FIFO with optional zero-latency head read
module uv_queue #(
  parameter int DAT_WIDTH = 32,
  parameter int PTR_WIDTH = 3,
  parameter int QUE_DEPTH = 2**PTR_WIDTH,
  parameter bit ZERO_RDLY = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 enq_vld,
  input  logic [DAT_WIDTH-1:0] enq_dat,
  input  logic                 deq_vld,
  output logic                 deq_rdy,
  output logic [DAT_WIDTH-1:0] deq_dat,
  output logic [PTR_WIDTH:0]   que_len
);

  logic [PTR_WIDTH:0]   wr_q, wr_d, rd_q, rd_d;
  logic [DAT_WIDTH-1:0] mem_q [QUE_DEPTH];
  logic [DAT_WIDTH-1:0] head;
  logic                 enq_ok, deq_ok;

  // Extra pointer MSB keeps full and empty distinct.
  assign que_len = wr_q - rd_q;
  assign deq_rdy = (que_len != '0);
  assign enq_ok  = enq_vld && (que_len < (PTR_WIDTH+1)'(QUE_DEPTH));
  assign deq_ok  = deq_vld && deq_rdy;
  assign head    = deq_rdy ? mem_q[rd_q[PTR_WIDTH-1:0]] : '0;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (enq_ok) wr_d = wr_q + (PTR_WIDTH+1)'(1);
      if (deq_ok) rd_d = rd_q + (PTR_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_ok && !clr) mem_q[wr_q[PTR_WIDTH-1:0]] <= enq_dat;
  end

  generate
    if (ZERO_RDLY) begin : g_zrd
      assign deq_dat = head;
    end else begin : g_rrd
      logic [DAT_WIDTH-1:0] out_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= head;
      end
      assign deq_dat = out_q;
    end
  endgenerate

endmodule

// File: rtl/uv_spi_rxpq.sv
// rtl/uv_spi_rxpq.sv - SPI RX packing queue: frames packed little-endian into FIFO words
module uv_spi_rxpq
  import uv_spi_pkg::*;
#(
  parameter int QUE_AW = 3,
  parameter int QUE_DP = 2**QUE_AW,
  parameter int QUE_DW = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frm_vld,
  input  logic [SPI_FRM_DW-1:0] frm_dat,
  input  logic                  frm_end,
  input  logic [1:0]            cfg_fsz,
  input  logic [QUE_AW:0]       cfg_thr,
  input  logic                  que_clr,
  output logic                  deq_rdy,
  input  logic                  deq_vld,
  output logic [QUE_DW-1:0]     deq_dat,
  output logic [QUE_AW:0]       que_len,
  output logic                  thr_irq,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam int IDX_W = $clog2(QUE_DW/8) + 1;

  logic [IDX_W-1:0]      pk_idx_q, pk_idx_d, idx_inc, slots;
  logic [QUE_DW-1:0]     pk_dat_q, pk_dat_d, pk_word, frm_sh;
  logic [SPI_FRM_DW-1:0] frm_msk;
  logic [5:0]            fbits;
  logic                  word_done, push, q_full;
  logic                  ovf_q, ovf_d;

  always_comb begin
    fbits     = fsz_bits(cfg_fsz);
    slots     = IDX_W'(QUE_DW / int'(fbits));
    frm_msk   = frm_dat & ((fbits == 6'd32) ? '1 : ((32'd1 << fbits) - 32'd1));
    frm_sh    = QUE_DW'(frm_msk) << (int'(pk_idx_q) * int'(fbits));
    pk_word   = frm_vld ? (pk_dat_q | frm_sh) : pk_dat_q;
    idx_inc   = frm_vld ? (pk_idx_q + IDX_W'(1)) : pk_idx_q;
    word_done = frm_vld && (idx_inc == slots);
    // A frame that both completes the word and ends the transfer still yields one push.
    push      = !que_clr && (word_done || (frm_end && (idx_inc != '0)));
    q_full    = (que_len == (QUE_AW+1)'(QUE_DP));

    pk_idx_d = idx_inc;
    pk_dat_d = pk_word;
    if (que_clr || push) begin
      pk_idx_d = '0;
      pk_dat_d = '0;
    end

    ovf_d = (push && q_full) || (ovf_q && !ovf_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_idx_q <= '0;
      pk_dat_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      pk_idx_q <= pk_idx_d;
      pk_dat_q <= pk_dat_d;
      ovf_q    <= ovf_d;
    end
  end

  uv_queue #(
    .DAT_WIDTH (QUE_DW),
    .PTR_WIDTH (QUE_AW),
    .QUE_DEPTH (QUE_DP),
    .ZERO_RDLY (1'b1)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (que_clr),
    .enq_vld (push),
    .enq_dat (pk_word),
    .deq_vld (deq_vld),
    .deq_rdy (deq_rdy),
    .deq_dat (deq_dat),
    .que_len (que_len)
  );

  assign ovf     = ovf_q;
  assign thr_irq = (cfg_thr != '0) && (que_len >= cfg_thr);

endmodule

// File: doc/uv_spi_rxpq.md
Name: uv_spi_rxpq

Overview:
Packing RX queue for the SPI master. It receives variable-size frames (8/16/32 bits) from the SPI shifter and packs them little-endian into QUE_DW-bit words. Words are stored in a zero-read-latency FIFO. Adds partial-word flush on frame end, sticky overflow and a watermark interrupt. Sits between the SPI shift engine and the SPI register/bus interface.

Parameters:
QUE_AW, 3, FIFO pointer width.
QUE_DP, 2**QUE_AW, FIFO depth in words.
QUE_DW, 32, queue word width; must be a multiple of 32.

Ports:
clk  in  1  clock.
rst_n  in  1  reset.
frm_vld  in  1  one received frame present this cycle; no backpressure.
frm_dat  in  32  frame data, right-aligned; bits above the frame size are ignored.
frm_end  in  1  transfer end (CS deassert) pulse; flushes the partial word.
cfg_fsz  in  2  frame size: 0=8, 1=16, 2=32, 3=treated as 32.
cfg_thr  in  QUE_AW+1  watermark level; 0 disables thr_irq.
que_clr  in  1  synchronous clear.
deq_rdy  out  1  word available (FIFO not empty).
deq_vld  in  1  pop request; honoured only when deq_rdy=1.
deq_dat  out  QUE_DW  head word, valid in the same cycle as deq_rdy.
que_len  out  QUE_AW+1  words stored, 0..QUE_DP.
thr_irq  out  1  watermark interrupt, level.
ovf  out  1  sticky overflow flag.
ovf_clr  in  1  clears ovf.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low. On reset: packer empty (slot index 0, shift reg 0), FIFO empty, deq_rdy=0, deq_dat=0, que_len=0, thr_irq=0, ovf=0.
- Packer:
  - Holds shift register pk_dat[QUE_DW-1:0] and slot index pk_idx; slots per word = QUE_DW/fsz.
  - On frm_vld, frame bits [fsz-1:0] are written at bit offset pk_idx*fsz, then pk_idx increments.
  - When the last slot is written, the word is pushed to the FIFO in the same cycle and pk_idx returns to 0.
- Flush:
  - On frm_end with pk_idx!=0, the partial word is pushed with unfilled upper slots set to 0, and pk_idx is reset to 0.
  - frm_vld and frm_end in the same cycle: the frame is included first, then flushed. Exactly one push occurs even if that frame completes the word.
  - frm_end with pk_idx=0 and no frm_vld: no push.
- Push: accepted only when que_len<QUE_DP at that cycle. A pop in the same cycle does not free a slot for that push.
- Overflow: a push refused because the FIFO is full drops the word and sets ovf=1 the next cycle. The packer still resets to slot 0.
- ovf_clr clears ovf. Simultaneous overflow and ovf_clr: ovf=1 (set wins).
- Latency: a frame completing a word at cycle N gives que_len+1 and deq_rdy=1 at cycle N+1.
- Pop: deq_vld & deq_rdy at cycle N advances the head and gives que_len-1 at N+1. deq_vld while empty is ignored.
- Simultaneous push and pop (not full): que_len unchanged; the FIFO order is preserved.
- Wrap-around: read and write pointers wrap modulo QUE_DP. que_len is computed with an extra MSB so that full (QUE_DP) and empty (0) are distinguishable.
- thr_irq: equals (que_len>=cfg_thr) && (cfg_thr!=0), derived from registered que_len with no extra cycle. cfg_thr>QUE_DP means thr_irq is never asserted.
- que_clr:
  - Empties the FIFO and discards the partial packer word; que_len=0 the next cycle.
  - It has priority over push, pop and frame input in the same cycle; the frame in that cycle is dropped.
  - It does not clear ovf.
- cfg_fsz is only changed while pk_idx=0. A change mid-word is undefined, and the bench must not test it.

Decomposition:
- Shared package uv_spi_pkg holds:
  - frame-size encodings: FSZ_8=2'd0, FSZ_16=2'd1, FSZ_32=2'd2;
  - the frame width constant SPI_FRM_DW=32.
- Storage is one instance of the existing uv_queue with ZERO_RDLY=1, DAT_WIDTH=QUE_DW, PTR_WIDTH=QUE_AW, QUE_DEPTH=QUE_DP.
- Packer, flush, overflow and irq logic stay in this module.

Test Plan:
1. fsz=8, frames 0x11,0x22,0x33,0x44 on consecutive cycles -> one cycle after the 4th frame: que_len=1, deq_rdy=1, deq_dat=0x44332211. Pop -> que_len=0.
2. fsz=16, frame 0xABCD, then frm_end alone -> deq_dat=0x0000ABCD. Frame 0x1234 with frm_vld and frm_end in the same cycle -> one word 0x00001234, que_len=2.
3. fsz=32, push 9 words 0..8 without popping -> que_len=8, ovf=1 after the 9th, popped data 0..7 in order. ovf_clr -> ovf=0. Repeat overflow with ovf_clr in the same cycle -> ovf=1.
4. cfg_thr=3, push 3 words -> thr_irq=1 in the cycle que_len=3. Pop one -> thr_irq=0. cfg_thr=0 with a full FIFO -> thr_irq=0.
5. 5 words stored plus 2 bytes packed (fsz=8), assert que_clr -> que_len=0, deq_rdy=0, ovf unchanged. Next 0xA1..0xA4 -> 0xA4A3A2A1.
6. Assert rst_n=0 asynchronously mid-word and with que_len=4 -> all outputs 0 immediately. After release, fsz=8 bytes 0x01..0x04 -> 0x04030201.
